// File: rtl/game_flow_controller_pkg.sv
// rtl/game_flow_controller_pkg.sv - shared state codes, defaults and score helper for the breakout round sequencer
//
// Purpose: state encodings shown on STATE, parameter defaults of
// game_flow_controller, datapath widths and the saturating score adder.
// Ports: none (package).

package game_flow_controller_pkg;

  // STATE codes driven to the display
  localparam logic [2:0] ST_ATTRACT = 3'd0;
  localparam logic [2:0] ST_SERVE   = 3'd1;
  localparam logic [2:0] ST_PLAY    = 3'd2;
  localparam logic [2:0] ST_LOST    = 3'd3;
  localparam logic [2:0] ST_CLEAR   = 3'd4;
  localparam logic [2:0] ST_OVER    = 3'd5;

  // Datapath widths
  localparam int SCORE_W = 14;
  localparam int TIMER_W = 8;

  // Default game tuning
  localparam int DEF_INITIAL_LIVES      = 3;
  localparam int DEF_POINTS_PER_BLOCK   = 10;
  localparam int DEF_SCORE_MAX          = 9999;
  localparam int DEF_LOST_DELAY_FRAMES  = 60;
  localparam int DEF_CLEAR_DELAY_FRAMES = 90;
  localparam int DEF_OVER_DELAY_FRAMES  = 180;

  // Sum is formed one bit wider so a carry out of 14 bits still saturates.
  function automatic logic [SCORE_W-1:0] satAddScore(
    input logic [SCORE_W-1:0] score,
    input logic [SCORE_W-1:0] inc,
    input logic [SCORE_W-1:0] maxVal
  );
    logic [SCORE_W:0] sum;
    sum = {1'b0, score} + {1'b0, inc};
    return (sum > {1'b0, maxVal}) ? maxVal : sum[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/game_flow_controller_frame_delay_timer.sv
// rtl/game_flow_controller_frame_delay_timer.sv - frame counter that pulses DONE on the LIMIT-th tick
//
// Purpose: counts FRAME_TICK pulses while CLEAR is low; DONE is asserted
// combinationally during the tick that brings the count to LIMIT, so the
// owner can change state on that same clock edge.
// Ports:
//   CLK, RESET_N  clock, asynchronous active-low reset
//   CLEAR         hold the count at zero
//   TICK          one-cycle frame pulse
//   LIMIT[7:0]    number of ticks to wait (1..255)
//   DONE          one-cycle pulse coincident with the LIMIT-th tick

module game_flow_controller_frame_delay_timer
  import game_flow_controller_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               CLEAR,
  input  logic               TICK,
  input  logic [TIMER_W-1:0] LIMIT,
  output logic               DONE
);

  logic [TIMER_W-1:0] count;
  logic [TIMER_W:0]   countNext;

  assign countNext = {1'b0, count} + {{TIMER_W{1'b0}}, 1'b1};
  assign DONE      = TICK && (countNext == {1'b0, LIMIT});

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      count <= '0;
    end else if (CLEAR) begin
      count <= '0;
    end else if (TICK) begin
      count <= countNext[TIMER_W-1:0];
    end
  end

endmodule

// File: rtl/game_flow_controller.sv
// rtl/game_flow_controller.sv - breakout round sequencer: physics gating, serve hold, level reload, lives and score
//
// Purpose: top-level game state machine between video timing, buttons and the
// physics/game-logic datapath.
// Ports:
//   CLK, RESET_N          clock, asynchronous active-low reset
//   FRAME_TICK           start-of-vblank pulse
//   BTN_RELEASE          debounced release/start button level
//   PHYS_BUSY            physics still running its substeps
//   BALL_LOST, BLOCK_HIT one-cycle game events
//   BLOCKS_REMAINING[6:0] live block count
//   START_UPDATE         pulse: run physics for this frame
//   SERVE_HOLD           level: park ball on paddle
//   LOAD_LEVEL           pulse: reload block pattern
//   LIVES[1:0], SCORE[13:0], STATE[2:0]  status
//   OVERRUN              sticky: frame tick seen while physics busy

module game_flow_controller
  import game_flow_controller_pkg::*;
#(
  parameter int INITIAL_LIVES      = DEF_INITIAL_LIVES,
  parameter int POINTS_PER_BLOCK   = DEF_POINTS_PER_BLOCK,
  parameter int SCORE_MAX          = DEF_SCORE_MAX,
  parameter int LOST_DELAY_FRAMES  = DEF_LOST_DELAY_FRAMES,
  parameter int CLEAR_DELAY_FRAMES = DEF_CLEAR_DELAY_FRAMES,
  parameter int OVER_DELAY_FRAMES  = DEF_OVER_DELAY_FRAMES
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               FRAME_TICK,
  input  logic               BTN_RELEASE,
  input  logic               PHYS_BUSY,
  input  logic               BALL_LOST,
  input  logic               BLOCK_HIT,
  input  logic [6:0]         BLOCKS_REMAINING,
  output logic               START_UPDATE,
  output logic               SERVE_HOLD,
  output logic               LOAD_LEVEL,
  output logic [1:0]         LIVES,
  output logic [SCORE_W-1:0] SCORE,
  output logic [2:0]         STATE,
  output logic               OVERRUN
);

  logic [2:0]         state;
  logic               btnPrev;
  logic               btnEdge;
  logic               runPhys;
  logic               inDelay;
  logic               timerDone;
  logic [TIMER_W-1:0] delayLimit;

  assign btnEdge    = BTN_RELEASE & ~btnPrev;
  assign runPhys    = (state == ST_SERVE) || (state == ST_PLAY);
  assign inDelay    = (state == ST_LOST) || (state == ST_CLEAR) || (state == ST_OVER);
  assign SERVE_HOLD = (state != ST_PLAY);
  assign STATE      = state;

  always_comb begin
    delayLimit = TIMER_W'(LOST_DELAY_FRAMES);
    case (state)
      ST_CLEAR: delayLimit = TIMER_W'(CLEAR_DELAY_FRAMES);
      ST_OVER:  delayLimit = TIMER_W'(OVER_DELAY_FRAMES);
      default:  ;
    endcase
  end

  // Held at zero outside the delay states, so it starts from zero on entry.
  game_flow_controller_frame_delay_timer uDelayTimer (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .CLEAR   (!inDelay),
    .TICK    (FRAME_TICK),
    .LIMIT   (delayLimit),
    .DONE    (timerDone)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= ST_ATTRACT;
      LIVES        <= 2'(INITIAL_LIVES);
      SCORE        <= '0;
      START_UPDATE <= 1'b0;
      LOAD_LEVEL   <= 1'b0;
      OVERRUN      <= 1'b0;
      btnPrev      <= 1'b0;
    end else begin
      btnPrev      <= BTN_RELEASE;
      START_UPDATE <= runPhys & FRAME_TICK & ~PHYS_BUSY;
      LOAD_LEVEL   <= 1'b0;
      if (runPhys & FRAME_TICK & PHYS_BUSY) begin
        OVERRUN <= 1'b1;
      end

      case (state)
        ST_ATTRACT: begin
          if (btnEdge) begin
            LOAD_LEVEL <= 1'b1;
            LIVES      <= 2'(INITIAL_LIVES);
            SCORE      <= '0;
            state      <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (btnEdge) begin
            state <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          // A hit is scored even when this cycle also leaves PLAY.
          if (BLOCK_HIT) begin
            SCORE <= satAddScore(SCORE, SCORE_W'(POINTS_PER_BLOCK), SCORE_W'(SCORE_MAX));
          end
          // Clearing the field wins over a simultaneous ball loss.
          if (BLOCKS_REMAINING == 7'd0) begin
            state <= ST_CLEAR;
          end else if (BALL_LOST) begin
            if (LIVES <= 2'd1) begin
              LIVES <= 2'd0;
              state <= ST_OVER;
            end else begin
              LIVES <= LIVES - 2'd1;
              state <= ST_LOST;
            end
          end
        end
        ST_LOST: begin
          if (timerDone) begin
            state <= ST_SERVE;
          end
        end
        ST_CLEAR: begin
          if (timerDone) begin
            LOAD_LEVEL <= 1'b1;
            state      <= ST_SERVE;
          end
        end
        ST_OVER: begin
          if (timerDone) begin
            state <= ST_ATTRACT;
          end
        end
        default: state <= ST_ATTRACT;
      endcase
    end
  end

endmodule
